// File: rtl/rsign_macro_dispatch.sv
// ---------------------------------------------------------------------------
// rsign_macro_dispatch
//
// Reader side of the RSign binarization stage. Each 3x3 binary activation
// window (FM_DEPTH channels x 9 bits) arrives with a 2-bit chs_macro tag and
// is captured into a two-entry ping-pong buffer. A small FSM then streams the
// window to the compute macros as one or two half-depth beats over a
// valid/ready handshake.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous, active-low reset
//   act_valid     one-cycle strobe: act_in / chs_macro_in carry a new window
//   act_in        FM_DEPTH x 9 binary activations from RSign
//   chs_macro_in  tag: bit0 = first half to send, bit1 = send both halves
//   macro_ready   macro bank accepts the current beat
//   macro_valid   beat on macro_act is valid
//   macro_act     FM_DEPTH/2 x 9 half-window payload
//   macro_half    half index of the current beat (0 lower, 1 upper)
//   macro_last    current beat is the final beat of its frame
//   buf_count     frames held in the buffer (0..2)
//   overflow      sticky: a frame was dropped because the buffer was full
// ---------------------------------------------------------------------------
module rsign_macro_dispatch #(
    parameter int FM_DEPTH = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         act_valid,
    input  logic [FM_DEPTH-1:0][8:0]     act_in,
    input  logic [1:0]                   chs_macro_in,
    input  logic                         macro_ready,
    output logic                         macro_valid,
    output logic [FM_DEPTH/2-1:0][8:0]   macro_act,
    output logic                         macro_half,
    output logic                         macro_last,
    output logic [1:0]                   buf_count,
    output logic                         overflow
);

    localparam int HALF = FM_DEPTH / 2;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    // Frame storage: payload and tag per entry. Contents are only meaningful
    // while counted in r_count, so they carry no reset.
    logic [FM_DEPTH-1:0][8:0] r_bufAct [2];
    logic [1:0]               r_bufTag [2];

    logic       r_wp;
    logic       r_rp;
    logic [1:0] r_count;
    logic       r_overflow;

    state_t             r_state;
    logic               r_valid;
    logic [HALF-1:0][8:0] r_act;
    logic               r_half;
    logic               r_last;

    logic                 w_handshake;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [1:0]           w_rdTag;
    logic [HALF-1:0][8:0] w_rdLower;
    logic [HALF-1:0][8:0] w_rdUpper;

    // A frame leaves the buffer only when its final beat is accepted; a full
    // buffer can still take a new frame in that same cycle.
    assign w_handshake = r_valid & macro_ready;
    assign w_pop       = w_handshake & r_last;
    assign w_full      = (r_count == 2'd2);
    assign w_push      = act_valid & (~w_full | w_pop);
    assign w_drop      = act_valid & w_full & ~w_pop;

    assign w_rdTag   = r_bufTag[r_rp];
    assign w_rdLower = r_bufAct[r_rp][HALF-1:0];
    assign w_rdUpper = r_bufAct[r_rp][FM_DEPTH-1:HALF];

    // Entry rp is never overwritten while it is being sent: a push into the
    // same entry only happens on the cycle its last beat is accepted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_bufAct[r_wp] <= act_in;
            r_bufTag[r_wp] <= chs_macro_in;
        end
    end

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Beat sequencer. IDLE always costs one cycle between frames because it
    // looks at the registered occupancy before loading beat 0. In SEND the
    // outputs hold until accepted; the second beat carries the other half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_act   <= '0;
            r_half  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != 2'd0) begin
                        r_valid <= 1'b1;
                        r_half  <= w_rdTag[0];
                        r_last  <= ~w_rdTag[1];
                        r_act   <= w_rdTag[0] ? w_rdUpper : w_rdLower;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_handshake) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_half <= ~r_half;
                            r_last <= 1'b1;
                            r_act  <= r_half ? w_rdLower : w_rdUpper;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign macro_valid = r_valid;
    assign macro_act   = r_act;
    assign macro_half  = r_half;
    assign macro_last  = r_last;
    assign buf_count   = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_rsign_macro_dispatch.sv
// ---------------------------------------------------------------------------
// tb_rsign_macro_dispatch
//
// Bench for rsign_macro_dispatch. A frame-queue model tracks which frames are
// buffered and which beat of the head frame is on the bus; a negedge compare
// process checks every output against it each cycle. Directed scenarios add
// hand-computed literal expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_rsign_macro_dispatch;

    localparam int FM   = 128;
    localparam int HALF = FM / 2;

    typedef logic [FM-1:0][8:0]   act_t;
    typedef logic [HALF-1:0][8:0] half_t;

    typedef struct {
        act_t       act;
        logic [1:0] tag;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       act_valid = 1'b0;
    act_t       act_in = '0;
    logic [1:0] chs_macro_in = 2'b00;
    logic       macro_ready = 1'b0;
    logic       macro_valid;
    half_t      macro_act;
    logic       macro_half;
    logic       macro_last;
    logic [1:0] buf_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Behavioural model state
    frame_t q[$];
    bit     mValid = 1'b0;
    int     beatIdx = 0;
    bit     mOvf = 1'b0;

    rsign_macro_dispatch #(.FM_DEPTH(FM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .act_valid    (act_valid),
        .act_in       (act_in),
        .chs_macro_in (chs_macro_in),
        .macro_ready  (macro_ready),
        .macro_valid  (macro_valid),
        .macro_act    (macro_act),
        .macro_half   (macro_half),
        .macro_last   (macro_last),
        .buf_count    (buf_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges beyond the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAct(input string name, input half_t actual, input half_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [1:0] tag, input act_t a, input bit rdy);
        act_valid    = v;
        chs_macro_in = tag;
        act_in       = a;
        macro_ready  = rdy;
    endtask

    function automatic int beatsOf(input frame_t f);
        return f.tag[1] ? 2 : 1;
    endfunction

    // Model: a FIFO of at most two frames plus the beat index of the head
    // frame currently on the bus. Updated with the inputs seen at each edge.
    always @(posedge clk or negedge rst_n) begin : model
        int     sz;
        bit     hs;
        bit     pop;
        bit     push;
        frame_t nf;
        if (!rst_n) begin
            q.delete();
            mValid  = 1'b0;
            beatIdx = 0;
            mOvf    = 1'b0;
        end else begin
            sz   = q.size();
            hs   = mValid && macro_ready;
            pop  = hs && (beatIdx == beatsOf(q[0]) - 1);
            push = act_valid && (sz < 2 || pop);
            if (act_valid && !push) mOvf = 1'b1;
            if (mValid) begin
                if (hs) begin
                    if (pop) mValid = 1'b0;
                    else     beatIdx = 1;
                end
            end else if (sz > 0) begin
                mValid  = 1'b1;
                beatIdx = 0;
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                nf.act = act_in;
                nf.tag = chs_macro_in;
                q.push_back(nf);
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin : compare
        frame_t f;
        bit     h;
        half_t  e;
        if (checkEn) begin
            checkOutput("buf_count", 32'(buf_count), 32'(q.size()));
            checkOutput("overflow", 32'(overflow), 32'(mOvf));
            checkOutput("macro_valid", 32'(macro_valid), 32'(mValid));
            if (mValid && q.size() > 0) begin
                f = q[0];
                h = (beatIdx == 0) ? f.tag[0] : ~f.tag[0];
                for (int c = 0; c < HALF; c++) e[c] = f.act[c + (h ? HALF : 0)];
                checkOutput("macro_half", 32'(macro_half), 32'(h));
                checkOutput("macro_last", 32'(macro_last), 32'(beatIdx == beatsOf(f) - 1));
                checkAct("macro_act", macro_act, e);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        applyStimulus(1'b0, 2'b00, act_in, 1'b1);
        while ((macro_valid || buf_count != 2'd0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) checkOutput("drain_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    function automatic act_t fillAct(input int base);
        act_t a;
        for (int c = 0; c < FM; c++) a[c] = 9'(c + base);
        return a;
    endfunction

    function automatic act_t constAct(input logic [8:0] v);
        act_t a;
        for (int c = 0; c < FM; c++) a[c] = v;
        return a;
    endfunction

    function automatic act_t randAct();
        act_t a;
        for (int c = 0; c < FM; c++) a[c] = 9'($urandom);
        return a;
    endfunction

    initial begin
        act_t pat;
        for (int c = 0; c < FM; c++)
            for (int k = 0; k < 9; k++)
                pat[c][k] = 1'((c % 2) ^ (k % 2));

        // Reset
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(macro_valid), 32'd0);
        checkOutput("reset_count", 32'(buf_count), 32'd0);
        checkAct("reset_act", macro_act, '0);
        rst_n = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);

        // Single two-half frame, ready held high
        applyStimulus(1'b1, 2'b10, pat, 1'b1);                    // cycle 0
        @(negedge clk); applyStimulus(1'b0, 2'b10, pat, 1'b1);    // cycle 1
        checkOutput("t1_c1_count", 32'(buf_count), 32'd1);
        checkOutput("t1_c1_valid", 32'(macro_valid), 32'd0);
        @(negedge clk);                                           // cycle 2
        checkOutput("t1_c2_valid", 32'(macro_valid), 32'd1);
        checkOutput("t1_c2_half", 32'(macro_half), 32'd0);
        checkOutput("t1_c2_last", 32'(macro_last), 32'd0);
        checkOutput("t1_c2_ch0", 32'(macro_act[0]), 32'h0AA);
        checkOutput("t1_c2_ch1", 32'(macro_act[1]), 32'h155);
        @(negedge clk);                                           // cycle 3
        checkOutput("t1_c3_half", 32'(macro_half), 32'd1);
        checkOutput("t1_c3_last", 32'(macro_last), 32'd1);
        checkOutput("t1_c3_ch0", 32'(macro_act[0]), 32'h0AA);
        @(negedge clk);                                           // cycle 4
        checkOutput("t1_c4_valid", 32'(macro_valid), 32'd0);
        drain();

        // Single-half frame, upper half only
        applyStimulus(1'b1, 2'b01, fillAct(0), 1'b1);
        @(negedge clk); applyStimulus(1'b0, 2'b01, act_in, 1'b1);
        @(negedge clk);                                           // cycle 2
        checkOutput("t2_c2_half", 32'(macro_half), 32'd1);
        checkOutput("t2_c2_last", 32'(macro_last), 32'd1);
        checkOutput("t2_c2_ch0", 32'(macro_act[0]), 32'd64);
        @(negedge clk);                                           // cycle 3
        checkOutput("t2_c3_count", 32'(buf_count), 32'd0);
        checkOutput("t2_c3_valid", 32'(macro_valid), 32'd0);
        drain();

        // Backpressure: ready low cycles 0..9, high from cycle 10
        applyStimulus(1'b1, 2'b10, fillAct(0), 1'b0);
        @(negedge clk); applyStimulus(1'b0, 2'b10, act_in, 1'b0);
        for (int cyc = 2; cyc <= 9; cyc++) begin
            @(negedge clk);
            checkOutput("t3_hold_ch0", 32'(macro_act[0]), 32'd0);
            checkOutput("t3_hold_half", 32'(macro_half), 32'd0);
        end
        @(negedge clk); macro_ready = 1'b1;                       // cycle 10
        checkOutput("t3_c10_half", 32'(macro_half), 32'd0);
        @(negedge clk);                                           // cycle 11
        checkOutput("t3_c11_half", 32'(macro_half), 32'd1);
        checkOutput("t3_c11_last", 32'(macro_last), 32'd1);
        checkOutput("t3_c11_ch0", 32'(macro_act[0]), 32'd64);
        drain();

        // Push/pop collision with a full buffer
        applyStimulus(1'b1, 2'b01, constAct(9'd7), 1'b0);         // cycle 0: A
        @(negedge clk); applyStimulus(1'b1, 2'b10, constAct(9'd8), 1'b0); // B
        @(negedge clk); applyStimulus(1'b0, 2'b10, act_in, 1'b0); // cycle 2
        checkOutput("t4_c2_count", 32'(buf_count), 32'd2);
        @(negedge clk); applyStimulus(1'b1, 2'b00, constAct(9'd9), 1'b1); // cycle 3: C
        @(negedge clk); applyStimulus(1'b0, 2'b00, act_in, 1'b1); // cycle 4
        checkOutput("t4_c4_count", 32'(buf_count), 32'd2);
        checkOutput("t4_c4_ovf", 32'(overflow), 32'd0);
        drain();

        // Overflow: three strobes, ready low
        applyStimulus(1'b1, 2'b00, constAct(9'd1), 1'b0);
        @(negedge clk); applyStimulus(1'b1, 2'b00, constAct(9'd2), 1'b0);
        @(negedge clk); applyStimulus(1'b1, 2'b00, constAct(9'd3), 1'b0);
        @(negedge clk); applyStimulus(1'b0, 2'b00, act_in, 1'b1); // cycle 3
        checkOutput("t5_c3_count", 32'(buf_count), 32'd2);
        checkOutput("t5_c3_ovf", 32'(overflow), 32'd1);
        checkOutput("t5_c3_ch0", 32'(macro_act[0]), 32'd1);
        @(negedge clk); @(negedge clk);                           // cycle 5
        checkOutput("t5_c5_valid", 32'(macro_valid), 32'd1);
        checkOutput("t5_c5_ch0", 32'(macro_act[0]), 32'd2);
        @(negedge clk);                                           // cycle 6
        checkOutput("t5_c6_count", 32'(buf_count), 32'd0);
        drain();
        checkOutput("t5_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-frame
        applyStimulus(1'b1, 2'b10, fillAct(0), 1'b0);
        @(negedge clk); applyStimulus(1'b0, 2'b10, act_in, 1'b0);
        @(negedge clk);
        checkOutput("t6_pre_valid", 32'(macro_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(macro_valid), 32'd0);
        checkOutput("t6_rst_count", 32'(buf_count), 32'd0);
        checkOutput("t6_rst_ovf", 32'(overflow), 32'd0);
        checkAct("t6_rst_act", macro_act, '0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 2'b11, fillAct(5), 1'b1);
        @(negedge clk); applyStimulus(1'b0, 2'b11, act_in, 1'b1);
        @(negedge clk);                                           // cycle 2
        checkOutput("t6_c2_half", 32'(macro_half), 32'd1);
        checkOutput("t6_c2_last", 32'(macro_last), 32'd0);
        checkOutput("t6_c2_ch0", 32'(macro_act[0]), 32'd69);
        @(negedge clk);                                           // cycle 3
        checkOutput("t6_c3_half", 32'(macro_half), 32'd0);
        checkOutput("t6_c3_ch0", 32'(macro_act[0]), 32'd5);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 2) == 0), 2'($urandom), randAct(),
                          ($urandom_range(0, 3) != 0));
            @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsign_macro_dispatch.md
# rsign_macro_dispatch

Reader side of the RSign binarization stage. It captures each 3×3 binary activation window (FM_DEPTH channels × 9 bits) together with its chs_macro tag into a two-frame ping-pong buffer. It then sends the window to the eight compute macros as one or two half-depth beats over a valid/ready handshake. It sits between the RSign output register and the macro input bank of each layer.

## Interface
- FM_DEPTH, 128, channel count. Must be even. Each beat carries FM_DEPTH/2 channels.
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- act_valid  in  1  one-cycle strobe: act_in and chs_macro_in hold a new window this cycle.
- act_in  in  1 × [FM_DEPTH-1:0][8:0]  binary activations from RSign.
- chs_macro_in  in  2  frame tag:
  - bit0: first half to send (0 = channels [FM_DEPTH/2-1:0], 1 = upper channels).
  - bit1: 1 = send both halves, 0 = send only the bit0 half.
- macro_ready  in  1  macro bank accepts the current beat.
- macro_valid  out  1  beat on macro_act is valid.
- macro_act  out  1 × [FM_DEPTH/2-1:0][8:0]  half-window to the macros.
- macro_half  out  1  half index of the current beat (0 lower, 1 upper).
- macro_last  out  1  current beat is the final beat of its frame.
- buf_count  out  2  frames held in the buffer (0..2).
- overflow  out  1  sticky flag: a frame was dropped because the buffer was full.

## Operation
- Buffer: two entries, each holding FM_DEPTH×9 bits plus a 2-bit tag. Write pointer wp and read pointer rp are 1 bit each. buf_count is registered.
- Push: act_valid=1 and (buf_count<2, or a pop completes in the same cycle) → store in entry wp, toggle wp, increment buf_count.
- Drop: act_valid=1, buf_count==2, and no pop in that cycle → frame discarded, overflow set to 1. overflow clears only on reset.
- Pop: the handshake (macro_valid & macro_ready) of a beat with macro_last=1 frees entry rp, toggles rp, and decrements buf_count.
- Simultaneous push and pop: buf_count unchanged, both pointers toggle.
- FSM states:
  - IDLE: macro_valid=0. If buf_count>0, load beat 0 of entry rp into the output registers, set macro_valid=1, go to SEND.
  - SEND: hold the outputs until macro_ready=1.
    - On handshake with macro_last=0: load beat 1 (half = ~bit0, macro_last=1). Stay in SEND; macro_valid stays 1.
    - On handshake with macro_last=1: pop, set macro_valid=0, go to IDLE.
- Beat 0 fields:
  - macro_half = tag bit0.
  - macro_last = ~tag bit1.
  - macro_act = act[FM_DEPTH/2-1:0] if half=0, otherwise act[FM_DEPTH-1:FM_DEPTH/2].
- Handshake rules: while macro_valid=1 and macro_ready=0, macro_act, macro_half and macro_last hold stable. macro_valid never drops without a handshake.
- Reset (asynchronous, any state, including mid-frame): the FSM goes to IDLE and all outputs take their reset values:
  - macro_valid=0, macro_act all 0, macro_half=0, macro_last=0.
  - buf_count=0, overflow=0; wp=rp=0.
  - Buffered frames are discarded; buffer data contents need no reset.

## Timing
- act_valid high in cycle 0 with the buffer empty and the FSM in IDLE:
  - buf_count=1 in cycle 1.
  - macro_valid=1 in cycle 2 (2-cycle latency).
- With macro_ready held at 1:
  - Two-half frame: beats in cycles 2 and 3; macro_valid=0 in cycle 4.
  - Next buffered frame's first beat: cycle 5.
- There is one mandatory bubble cycle (IDLE) between frames.
- Sustained throughput is one frame per 3 cycles (two-half frames) or per 2 cycles (single-half frames).
- All outputs are registered. There is no combinational path from macro_ready or act_valid to any output.

## Test plan
- Single frame:
  - Stimulus: tag=2'b10, act_in[c][k]=c[0]^k[0], macro_ready=1.
  - Required response: beats in cycles 2 and 3 with half=0 then half=1, macro_last=0 then 1. Payloads match the lower and upper channels bit-exactly.
- Single-half frame:
  - Stimulus: tag=2'b01.
  - Required response: exactly one beat, half=1, macro_last=1; buf_count returns to 0 in cycle 3.
- Backpressure:
  - Stimulus: macro_ready=0 for cycles 2–9, then 1.
  - Required response: beat-0 outputs are constant for cycles 2–9; beat 1 appears in cycle 11.
- Overflow:
  - Stimulus: macro_ready=0; three act_valid strobes in cycles 0, 1, 2 with distinct payloads.
  - Required response: buf_count=2 and overflow=1 from cycle 3. After macro_ready=1, only frames 0 and 1 are delivered, in order.
- Push/pop collision:
  - Stimulus: buf_count=2 and an act_valid in the same cycle as the last-beat handshake.
  - Required response: frame accepted, buf_count stays 2, overflow stays 0.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 while in SEND after beat 0.
  - Required response: macro_valid=0 and buf_count=0 immediately. A frame pushed after reset is delivered starting with its beat 0.
